// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle unsigned multiply/divide unit for the EX stage.
//               An iterative shift-add multiplier produces the low WIDTH bits
//               of the product. A restoring divider produces the quotient and
//               the remainder. While an operation runs, stall_o holds the
//               upstream pipeline stages.
// Ports       : clk          - rising-edge clock
//               rst_n        - synchronous active-low reset
//               valid_i      - EX stage holds an instruction this cycle
//               ALU_select_i - ALU opcode (0011 = multiply, 0100 = divide)
//               data1_i      - multiplicand / dividend
//               data2_i      - multiplier / divisor
//               flush_i      - pipeline flush, aborts any operation
//               ready_o      - idle, able to accept an operation
//               busy_o       - operation in progress
//               stall_o      - hold the upstream pipeline stages
//               done_o       - one-cycle pulse, result/rem/z valid
//               result_o     - product (low WIDTH bits) or quotient
//               rem_o        - division remainder, 0 after a multiply
//               z_o          - result_o == 0
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [3:0]       ALU_select_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             z_o
);

  localparam logic [3:0]       C_OP_MUL   = 4'b0011;
  localparam logic [3:0]       C_OP_DIV   = 4'b0100;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Datapath registers are shared between the two operations:
  //   a : multiply accumulator  / divide partial remainder
  //   b : multiplicand          / divisor
  //   c : multiplier            / quotient shift register
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             z_q, z_d;

  logic             w_is_op;
  logic             w_accept;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_sub;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  assign w_is_op  = (ALU_select_i == C_OP_MUL) || (ALU_select_i == C_OP_DIV);
  assign w_accept = (state_q == S_IDLE) && valid_i && w_is_op && !flush_i;

  // One shift-add multiply iteration.
  assign w_mul_acc = c_q[0] ? (a_q + b_q) : a_q;

  // One restoring divide step. The shifted remainder needs an extra bit
  // because it can reach 2*divisor-1 before the subtraction; the difference
  // itself always fits in WIDTH bits.
  assign w_rem_sh  = {a_q, c_q[WIDTH-1]};
  assign w_div_ge  = (w_rem_sh >= {1'b0, b_q});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - b_q;
  assign w_div_rem = w_div_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_div_quo = {c_q[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      rem_q    <= '0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      z_q      <= z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    rem_d    = rem_q;
    z_d      = z_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (ALU_select_i == C_OP_MUL) begin
            state_d = S_MUL;
            a_d     = '0;
            b_d     = data1_i;
            c_d     = data2_i;
            cnt_d   = C_CNT_INIT;
          end else if (data2_i == '0) begin
            // Divide by zero completes immediately.
            state_d  = S_DONE;
            result_d = '1;
            rem_d    = data1_i;
            z_d      = 1'b0;
          end else begin
            state_d = S_DIV;
            a_d     = '0;
            b_d     = data2_i;
            c_d     = data1_i;
            cnt_d   = C_CNT_INIT;
          end
        end
      end

      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          a_d   = w_mul_acc;
          b_d   = b_q << 1;
          c_d   = c_q >> 1;
          cnt_d = cnt_q - 1'b1;
          // cnt_q == 1 marks the final (WIDTH-th) iteration.
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            result_d = w_mul_acc;
            rem_d    = '0;
            z_d      = (w_mul_acc == '0);
          end
        end
      end

      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          a_d   = w_div_rem;
          c_d   = w_div_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            result_d = w_div_quo;
            rem_d    = w_div_rem;
            z_d      = (w_div_quo == '0);
          end
        end
      end

      S_DONE: begin
        // The done cycle never accepts; the pipeline advances this cycle.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready_o  = (state_q == S_IDLE);
  assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
  assign stall_o  = busy_o || w_accept;
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign rem_o    = rem_q;
  assign z_o      = z_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. A table of
//               operations with hand-computed results is applied in a loop,
//               followed by directed sequences for flush, reset, ignored
//               opcodes and the back-to-back boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic [3:0]       ALU_select_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic             ready_o;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] rem_o;
  logic             z_o;

  int n_total;
  int n_pass;

  muldiv_sequencer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ALU_select_i (ALU_select_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .flush_i      (flush_i),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .rem_o        (rem_o),
    .z_o          (z_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rem;
    logic             z;
    int               lat;   // rising edges from accept edge (inclusive) to done
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one operation from IDLE and check its completion.
  task automatic run_op(input vec_t v, input int idx);
    int  cyc;
    bit  stall_ok;
    @(negedge clk);
    valid_i = 1'b1; ALU_select_i = v.op; data1_i = v.d1; data2_i = v.d2;
    #1;
    chk($sformatf("v%0d_stall_at_accept", idx), 64'(stall_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; ALU_select_i = 4'b0000; data1_i = '1; data2_i = '1;
    cyc = 0; stall_ok = 1'b1;
    while (!done_o && cyc < 200) begin
      if (!stall_o || !busy_o) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_done", idx),      64'(done_o),   64'd1);
    chk($sformatf("v%0d_latency", idx),   64'(cyc + 1),  64'(v.lat));
    chk($sformatf("v%0d_stall_held", idx),64'(stall_ok), 64'd1);
    chk($sformatf("v%0d_result", idx),    result_o,      v.res);
    chk($sformatf("v%0d_rem", idx),       rem_o,         v.rem);
    chk($sformatf("v%0d_z", idx),         64'(z_o),      64'(v.z));
    chk($sformatf("v%0d_stall_in_done", idx), 64'(stall_o), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done_one_cycle", idx), 64'(done_o),  64'd0);
    chk($sformatf("v%0d_ready_after", idx),    64'(ready_o), 64'd1);
    chk($sformatf("v%0d_result_hold", idx),    result_o,     v.res);
  endtask

  // Watch a number of cycles and report whether done was ever seen.
  task automatic watch_no_done(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int cyc;
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; valid_i = 1'b0; ALU_select_i = 4'b0000;
    data1_i = '0; data2_i = '0; flush_i = 1'b0;

    vecs[0] = '{4'b0011, 64'd7, 64'd6, 64'd42, 64'd0, 1'b0, 65};
    vecs[1] = '{4'b0100, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65};
    vecs[2] = '{4'b0100, 64'd5, 64'd9, 64'd0, 64'd5, 1'b1, 65};
    vecs[3] = '{4'b0011, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'd0, 1'b1, 65};
    vecs[4] = '{4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 65};
    vecs[5] = '{4'b0100, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123, 1'b0, 1};
    vecs[6] = '{4'b0011, 64'd1000, 64'd1000, 64'd1000000, 64'd0, 1'b0, 65};
    vecs[7] = '{4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 64'd0, 1'b0, 65};
    vecs[8] = '{4'b0100, 64'h1234_5678_9ABC_DEF0, 64'h1_0000, 64'h0000_1234_5678_9ABC, 64'hDEF0, 1'b0, 65};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  64'(ready_o), 64'd1);
    chk("rst_busy",   64'(busy_o),  64'd0);
    chk("rst_done",   64'(done_o),  64'd0);
    chk("rst_stall",  64'(stall_o), 64'd0);
    chk("rst_result", result_o,     64'd0);
    chk("rst_rem",    rem_o,        64'd0);
    chk("rst_z",      64'(z_o),     64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i], i);

    // Non-muldiv opcode is ignored
    @(negedge clk);
    valid_i = 1'b1; ALU_select_i = 4'b0010; data1_i = 64'd3; data2_i = 64'd4;
    #1;
    chk("other_op_stall", 64'(stall_o), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("other_op_ready", 64'(ready_o), 64'd1);
    chk("other_op_busy",  64'(busy_o),  64'd0);

    // Flush together with a multiply in IDLE: not accepted
    ALU_select_i = 4'b0011; flush_i = 1'b1;
    #1;
    chk("idle_flush_stall", 64'(stall_o), 64'd0);
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush_busy",  64'(busy_o),  64'd0);
    chk("idle_flush_ready", 64'(ready_o), 64'd1);
    watch_no_done("idle_flush_no_done", 70);

    // Flush at iteration 10 of a multiply
    @(negedge clk);
    valid_i = 1'b1; ALU_select_i = 4'b0011; data1_i = 64'd3; data2_i = 64'd3;
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("mul_flush_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); @(negedge clk);
    flush_i = 1'b0;
    chk("mul_flush_busy",   64'(busy_o),  64'd0);
    chk("mul_flush_ready",  64'(ready_o), 64'd1);
    chk("mul_flush_result", result_o,     64'h0000_1234_5678_9ABC);
    chk("mul_flush_rem",    rem_o,        64'hDEF0);
    watch_no_done("mul_flush_no_done", 70);

    // Reset at iteration 30 of a divide
    @(negedge clk);
    valid_i = 1'b1; ALU_select_i = 4'b0100; data1_i = 64'd1000; data2_i = 64'd3;
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0;
    repeat (29) @(negedge clk);
    chk("div_rst_busy_before", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("div_rst_ready",  64'(ready_o), 64'd1);
    chk("div_rst_busy",   64'(busy_o),  64'd0);
    chk("div_rst_result", result_o,     64'd0);
    chk("div_rst_rem",    rem_o,        64'd0);
    chk("div_rst_z",      64'(z_o),     64'd0);
    watch_no_done("div_rst_no_done", 70);

    // Back-to-back: the DONE cycle does not accept a waiting operation
    @(negedge clk);
    valid_i = 1'b1; ALU_select_i = 4'b0100; data1_i = 64'd50; data2_i = 64'd0;
    @(posedge clk); @(negedge clk);
    chk("b2b_dz_done",   64'(done_o), 64'd1);
    chk("b2b_dz_result", result_o,    64'hFFFF_FFFF_FFFF_FFFF);
    chk("b2b_dz_rem",    rem_o,       64'd50);
    ALU_select_i = 4'b0011; data1_i = 64'd2; data2_i = 64'd3;
    #1;
    chk("b2b_done_stall", 64'(stall_o), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("b2b_idle_ready", 64'(ready_o), 64'd1);
    chk("b2b_idle_busy",  64'(busy_o),  64'd0);
    chk("b2b_idle_stall", 64'(stall_o), 64'd1);
    @(posedge clk); @(negedge clk);
    valid_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_mul_done",    64'(done_o),  64'd1);
    chk("b2b_mul_latency", 64'(cyc + 1), 64'd65);
    chk("b2b_mul_result",  result_o,     64'd6);
    chk("b2b_mul_rem",     rem_o,        64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the ALU's multiply (ALU_select 4'b0011) and divide (ALU_select 4'b0100) operations.
- Replaces the single-cycle combinational multiply and divide with an iterative shift-add multiplier and a restoring divider.
- Sits in the EX stage beside the combinational ALU. It raises stall to freeze the earlier pipeline stages until the result is ready.
- Operands are unsigned. The multiply result is the low WIDTH bits of the product.

Parameters:
- WIDTH, 64, operand and result width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- valid  input  1  EX stage holds an instruction this cycle.
- ALU_select  input  4  ALU opcode; only 4'b0011 and 4'b0100 are acted on.
- data1  input  WIDTH  multiplicand or dividend.
- data2  input  WIDTH  multiplier or divisor.
- flush  input  1  pipeline flush; aborts any operation.
- ready  output  1  sequencer idle and able to accept an operation.
- busy  output  1  operation in progress (state MUL or DIV).
- stall  output  1  hold the upstream pipeline stages.
- done  output  1  one-cycle pulse: result, rem and z are valid.
- result  output  WIDTH  product (low WIDTH bits) or quotient.
- rem  output  WIDTH  division remainder; 0 after a multiply.
- z  output  1  result == 0, registered with result.

Behaviour:
- Reset (rst_n low at an edge):
  - state = IDLE; counter = 0; all internal registers = 0.
  - Outputs: result = 0, rem = 0, z = 0, done = 0, busy = 0, ready = 1.
  - Reset overrides every other input, including mid-operation; no done is produced for the aborted operation.
- States: IDLE, MUL, DIV, DONE.
- Accept:
  - Condition: state == IDLE, valid = 1, ALU_select is 0011 or 0100, flush = 0.
  - Operands are latched at the accepting edge.
  - Other opcodes are ignored: no state change, stall = 0.
- IDLE -> MUL on an accepted 0011.
  - Load acc = 0, mcand = data1, mplier = data2, counter = WIDTH.
- IDLE -> DIV on an accepted 0100 with data2 != 0.
  - Load quotient shift register = data1, partial remainder = 0, divisor = data2, counter = WIDTH.
- IDLE -> DONE on an accepted 0100 with data2 == 0 (divide by zero).
  - result = all ones, rem = data1, z = 0.
- MUL, one iteration per edge:
  - If mplier[0] = 1, add mcand to acc (mod 2^WIDTH).
  - Shift mcand left by 1 and mplier right by 1; decrement counter.
  - When counter reaches 1 on this edge, go to DONE and register result, rem = 0 and z.
- DIV, one restoring step per edge:
  - Shift {partial remainder, quotient} left by 1.
  - If partial remainder >= divisor: subtract divisor and set quotient bit 0 to 1.
  - Decrement counter; on the last step go to DONE and register quotient, remainder and z.
- Latency:
  - done is high in the cycle after WIDTH+1 rising edges following the accept edge (65 for WIDTH = 64).
  - Divide by zero: done after 1 edge.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - result, rem and z hold their values until the next operation completes.
- Output decode:
  - ready = (state == IDLE); busy = (state == MUL or DIV).
  - stall is combinational: 1 when busy, or when state == IDLE with valid = 1, a muldiv opcode and flush = 0. stall = 0 in DONE, so the pipeline advances and captures the result.
- Back-to-back: a new operation can be accepted no earlier than the first cycle after DONE. The DONE cycle itself is never an accept cycle.
- Flush:
  - In MUL or DIV: go to IDLE at the next edge; no done; result, rem and z keep their old values.
  - In IDLE with valid at the same edge: flush wins and the operation is not accepted.
  - In DONE: done still pulses; state goes to IDLE.
- Inputs valid, ALU_select, data1 and data2 are don't-care while busy.

Test Plan:
- Multiply: reset, then 0011 with data1 = 7, data2 = 6 -> stall high for 65 cycles; then done = 1 for one cycle with result = 42, rem = 0, z = 0; next cycle ready = 1.
- Divide: 0100 with data1 = 100, data2 = 7 -> done after 65 edges with result = 14, rem = 2, z = 0. Then 0100 with 5 / 9 -> result = 0, rem = 5, z = 1.
- Multiply overflow: data1 = 64'h8000_0000_0000_0000, data2 = 2 -> result = 0, z = 1. Then 64'hFFFF_FFFF_FFFF_FFFF × 64'hFFFF_FFFF_FFFF_FFFF -> result = 1.
- Divide by zero: data1 = 123, data2 = 0 -> done one edge after accept with result = all ones, rem = 123, z = 0.
- Flush and reset mid-operation:
  - Flush at iteration 10 of a multiply -> busy = 0 and ready = 1 at the next edge; no done; result unchanged.
  - rst_n low at iteration 30 of a divide -> all outputs return to their reset values; no done.
- Non-muldiv opcode: valid = 1 with ALU_select = 0010 -> stall = 0, ready stays 1, no state change. Flush asserted together with a 0011 in IDLE -> not accepted, busy stays 0.
